// File: rtl/fetch_stage.sv
// fetch_stage: WISC instruction fetch (PC, imem handshake, skid buffer, IF/ID register).
// Define FETCH_PERF_CNT_EN to build the saturating stall/drop performance counters.
module fetch_stage #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0] HALT_OP = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              if_valid,
    output logic [15:0]       if_instr,
    output logic [3:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc_plus2,
    output logic              halted,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_drop_cnt
);
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, HALT} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, fetch_pc, fetch_pc_nx, pc_inc, skid_pc2, skid_pc2_nx, if_pc_plus2_nx;
    logic [15:0] skid_instr, skid_instr_nx, if_instr_nx;
    logic drop, drop_nx, if_valid_nx, load;

    assign pc_inc    = fetch_pc + ADDR_W'(2);
    assign imem_req  = rst_n && state == ISSUE && !br_taken;
    assign imem_addr = pc;
    assign if_opcode = if_instr[15:12];
    assign halted    = state == HALT;

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        fetch_pc_nx    = fetch_pc;
        drop_nx        = drop;
        skid_instr_nx  = skid_instr;
        skid_pc2_nx    = skid_pc2;
        load           = 1'b0;
        if_instr_nx    = if_instr;
        if_pc_plus2_nx = if_pc_plus2;
        case (state)
            ISSUE: begin
                if (br_taken) pc_nx = br_target;
                else begin
                    fetch_pc_nx = pc;
                    state_nx    = WAIT;
                end
            end
            WAIT: begin
                // a redirect poisons the outstanding request unless its response lands now
                if (br_taken) begin
                    pc_nx   = br_target;
                    drop_nx = !imem_ready;
                    if (imem_ready) state_nx = ISSUE;
                end else if (imem_ready && drop) begin
                    drop_nx  = 1'b0;
                    state_nx = ISSUE;
                end else if (imem_ready && stall) begin
                    pc_nx         = pc_inc;
                    skid_instr_nx = imem_rdata;
                    skid_pc2_nx   = pc_inc;
                    state_nx      = HOLD;
                end else if (imem_ready) begin
                    pc_nx          = pc_inc;
                    load           = 1'b1;
                    if_instr_nx    = imem_rdata;
                    if_pc_plus2_nx = pc_inc;
                    state_nx       = imem_rdata[15:12] == HALT_OP ? HALT : ISSUE;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_nx         = br_target;
                    skid_instr_nx = '0;
                    skid_pc2_nx   = '0;
                    state_nx      = ISSUE;
                end else if (!stall) begin
                    load           = 1'b1;
                    if_instr_nx    = skid_instr;
                    if_pc_plus2_nx = skid_pc2;
                    state_nx       = skid_instr[15:12] == HALT_OP ? HALT : ISSUE;
                end
            end
            default: begin
                if (br_taken) begin
                    pc_nx    = br_target;
                    state_nx = ISSUE;
                end
            end
        endcase
        if_valid_nx = !br_taken && (stall ? if_valid : load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ISSUE;
            pc          <= RESET_PC;
            fetch_pc    <= RESET_PC;
            drop        <= 1'b0;
            skid_instr  <= '0;
            skid_pc2    <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc_plus2 <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            fetch_pc    <= fetch_pc_nx;
            drop        <= drop_nx;
            skid_instr  <= skid_instr_nx;
            skid_pc2    <= skid_pc2_nx;
            if_valid    <= if_valid_nx;
            if_instr    <= if_instr_nx;
            if_pc_plus2 <= if_pc_plus2_nx;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic drop_evt;
    assign drop_evt = (state == WAIT && imem_ready && (drop || br_taken)) || (state == HOLD && br_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (stall && if_valid && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (drop_evt && perf_drop_cnt != 16'hFFFF) perf_drop_cnt <= perf_drop_cnt + 16'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed cycle table, reset-in-WAIT sequence and randomized run against a fetch-stream model.
module tb_fetch_stage;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic imem_ready, stall, br_taken, imem_req, if_valid, halted;
    logic [15:0] imem_rdata, br_target, imem_addr, if_instr, if_pc_plus2, perf_stall_cnt, perf_drop_cnt;
    logic [3:0] if_opcode;
    logic ready_b = 1'b1, zero_b = 1'b0, req_b, valid_b, halted_b;
    logic [15:0] rdata_b = 16'h1000, tgt_b = 16'h0000, addr_b, instr_b, pc2_b, pstall_b, pdrop_b;
    logic [3:0] op_b;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
        .if_pc_plus2(if_pc_plus2), .halted(halted), .perf_stall_cnt(perf_stall_cnt),
        .perf_drop_cnt(perf_drop_cnt)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ready(ready_b), .imem_rdata(rdata_b), .stall(zero_b), .br_taken(zero_b),
        .br_target(tgt_b), .if_valid(valid_b), .if_instr(instr_b), .if_opcode(op_b),
        .if_pc_plus2(pc2_b), .halted(halted_b), .perf_stall_cnt(pstall_b),
        .perf_drop_cnt(pdrop_b)
    );

    typedef struct {
        logic stall, br;
        logic [15:0] tgt;
        logic req;
        logic [15:0] addr;
        logic valid;
        logic [15:0] instr, pc2;
        logic halted;
    } vec_t;
    vec_t tbl[29];

    int total = 0, bad = 0;
    logic pend = 1'b0, q_valid = 1'b0, m_valid;
    logic [15:0] pend_addr, q_instr, q_addr, m_instr, m_pc2, exp_addr;
    int cnt = 0, delivered = 0, stall_model = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic s, input logic b, input logic [15:0] t, input logic r,
                               input logic [15:0] a, input logic vl, input logic [15:0] in,
                               input logic [15:0] p2, input logic h);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.req = r; x.addr = a;
        x.valid = vl; x.instr = in; x.pc2 = p2; x.halted = h;
        return x;
    endfunction

    function automatic logic [15:0] memf(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0002: return 16'hA5F0;
            16'h0006: return 16'hF000;
            default:  return {4'h2, a[11:0]};
        endcase
    endfunction

    // memory answers a request `lat` cycles after the request cycle
    task automatic mem_drive(input bit rnd);
        if (pend && cnt == 0) begin
            imem_ready = 1'b1;
            imem_rdata = rnd ? {4'($urandom_range(0, 14)), 12'($urandom)} : memf(pend_addr);
            pend = 1'b0;
            if (rnd) begin
                q_valid = 1'b1;
                q_instr = imem_rdata;
                q_addr  = pend_addr;
            end
        end else begin
            imem_ready = 1'b0;
            imem_rdata = 16'($urandom);
            if (pend) cnt--;
        end
    endtask

    task automatic mem_req(input int lat);
        if (imem_req) begin
            pend = 1'b1;
            pend_addr = imem_addr;
            cnt = lat - 1;
        end
    endtask

    initial begin
        tbl[0]  = v(0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[1]  = v(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[2]  = v(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h0002, 0);
        tbl[3]  = v(0, 0, 16'h0000, 1, 16'h0002, 0, 16'h1234, 16'h0002, 0);
        tbl[4]  = v(1, 0, 16'h0000, 0, 16'h0002, 0, 16'h1234, 16'h0002, 0);
        tbl[5]  = v(1, 0, 16'h0000, 0, 16'h0002, 0, 16'h1234, 16'h0002, 0);
        tbl[6]  = v(1, 0, 16'h0000, 0, 16'h0004, 0, 16'h1234, 16'h0002, 0);
        tbl[7]  = v(0, 0, 16'h0000, 0, 16'h0004, 1, 16'hA5F0, 16'h0004, 0);
        tbl[8]  = v(0, 0, 16'h0000, 1, 16'h0004, 0, 16'hA5F0, 16'h0004, 0);
        tbl[9]  = v(0, 0, 16'h0000, 0, 16'h0004, 0, 16'hA5F0, 16'h0004, 0);
        tbl[10] = v(0, 1, 16'h0040, 0, 16'h0004, 0, 16'hA5F0, 16'h0004, 0);
        tbl[11] = v(0, 0, 16'h0000, 1, 16'h0040, 0, 16'hA5F0, 16'h0004, 0);
        tbl[12] = v(0, 0, 16'h0000, 0, 16'h0040, 0, 16'hA5F0, 16'h0004, 0);
        tbl[13] = v(0, 0, 16'h0000, 0, 16'h0040, 1, 16'h2040, 16'h0042, 0);
        tbl[14] = v(0, 1, 16'h0006, 0, 16'h0042, 0, 16'h2040, 16'h0042, 0);
        tbl[15] = v(0, 0, 16'h0000, 1, 16'h0006, 0, 16'h2040, 16'h0042, 0);
        tbl[16] = v(0, 0, 16'h0000, 0, 16'h0006, 0, 16'h2040, 16'h0042, 0);
        tbl[17] = v(0, 0, 16'h0000, 0, 16'h0006, 1, 16'hF000, 16'h0008, 1);
        tbl[18] = v(0, 0, 16'h0000, 0, 16'h0008, 0, 16'hF000, 16'h0008, 1);
        tbl[19] = v(0, 0, 16'h0000, 0, 16'h0008, 0, 16'hF000, 16'h0008, 1);
        tbl[20] = v(0, 1, 16'h0010, 0, 16'h0008, 0, 16'hF000, 16'h0008, 0);
        tbl[21] = v(0, 0, 16'h0000, 1, 16'h0010, 0, 16'hF000, 16'h0008, 0);
        tbl[22] = v(0, 0, 16'h0000, 0, 16'h0010, 0, 16'hF000, 16'h0008, 0);
        tbl[23] = v(0, 0, 16'h0000, 0, 16'h0010, 1, 16'h2010, 16'h0012, 0);
        tbl[24] = v(1, 0, 16'h0000, 1, 16'h0012, 1, 16'h2010, 16'h0012, 0);
        tbl[25] = v(1, 0, 16'h0000, 0, 16'h0012, 1, 16'h2010, 16'h0012, 0);
        tbl[26] = v(1, 0, 16'h0000, 0, 16'h0012, 1, 16'h2010, 16'h0012, 0);
        tbl[27] = v(1, 1, 16'h0020, 0, 16'h0014, 0, 16'h2010, 16'h0012, 0);
        tbl[28] = v(0, 0, 16'h0000, 1, 16'h0020, 0, 16'h2010, 16'h0012, 0);

        imem_ready = 1'b0; imem_rdata = 16'h0000; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
        @(posedge clk); #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 16'h0000);
        chk("rst_pc2", if_pc_plus2, 16'h0000);
        chk("rst_halted", halted, 0);
        chk("rst_perf", {perf_stall_cnt, perf_drop_cnt}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            stall = tbl[i].stall; br_taken = tbl[i].br; br_target = tbl[i].tgt;
            mem_drive(0);
            #1;
            chk($sformatf("req[%0d]", i), imem_req, tbl[i].req);
            chk($sformatf("addr[%0d]", i), imem_addr, tbl[i].addr);
            if (i == 0) chk("wrap_req0", {req_b, addr_b}, {1'b1, 16'hFFFE});
            if (i == 2) chk("wrap_req1", {req_b, addr_b}, {1'b1, 16'h0000});
            mem_req(2);
            @(posedge clk); #1;
            chk($sformatf("valid[%0d]", i), if_valid, tbl[i].valid);
            chk($sformatf("instr[%0d]", i), if_instr, tbl[i].instr);
            chk($sformatf("opcode[%0d]", i), if_opcode, tbl[i].instr[15:12]);
            chk($sformatf("pc2[%0d]", i), if_pc_plus2, tbl[i].pc2);
            chk($sformatf("halted[%0d]", i), halted, tbl[i].halted);
            if (i == 1) chk("wrap_load", {valid_b, pc2_b}, {1'b1, 16'h0000});
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_dir", {perf_stall_cnt, perf_drop_cnt}, {16'd4, 16'd2});
`else
        chk("perf_dir", {perf_stall_cnt, perf_drop_cnt}, 32'h0);
`endif

        // reset while a request is outstanding; a stale response must not leak through
        stall = 1'b0; br_taken = 1'b0; imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_addr", imem_addr, 16'h0000);
        chk("arst_if", {if_valid, if_instr, if_pc_plus2, halted}, 34'h0);
        chk("arst_perf", {perf_stall_cnt, perf_drop_cnt}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pend = 1'b0;
        imem_ready = 1'b1; imem_rdata = 16'hBEEF;
        #1;
        chk("late_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
        @(posedge clk); #1;
        chk("late_valid", if_valid, 0);
        imem_rdata = 16'h1234;
        @(posedge clk); #1;
        chk("late_load", {if_valid, if_instr, if_pc_plus2}, {1'b1, 16'h1234, 16'h0002});
        imem_ready = 1'b0;

        m_valid = 1'b1; m_instr = 16'h1234; m_pc2 = 16'h0002; exp_addr = 16'h0002;
        for (int c = 0; c < 600; c++) begin
            stall = $urandom_range(0, 9) < 3;
            br_taken = 1'b0;
            mem_drive(1);
            #1;
            chk("rnd_req", imem_req, !pend && !q_valid);
            if (imem_req) begin
                chk("rnd_addr", imem_addr, exp_addr);
                exp_addr = exp_addr + 16'd2;
                mem_req($urandom_range(1, 4));
            end
            if (stall && m_valid) stall_model++;
            @(posedge clk); #1;
            if (!stall) begin
                m_valid = q_valid;
                if (q_valid) begin
                    m_instr = q_instr;
                    m_pc2 = q_addr + 16'd2;
                    q_valid = 1'b0;
                    delivered++;
                end
            end
            chk("rnd_if", {if_valid, if_instr, if_pc_plus2}, {m_valid, m_instr, m_pc2});
        end
        chk("rnd_progress", delivered >= 50, 1);
        chk("rnd_halted", halted, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_rnd", {perf_stall_cnt, perf_drop_cnt}, {16'(stall_model), 16'd0});
`else
        chk("perf_rnd", {perf_stall_cnt, perf_drop_cnt}, 32'h0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
